// File: rtl/acc_pkg.sv
// Accelerator offload defaults: requester count, ID extension widths and payload types.
package acc_pkg;

    localparam int unsigned DefaultNumReq         = 2;
    localparam int unsigned DefaultInIdWidth      = 5;
    localparam int unsigned DefaultMaxOutstanding = 4;
    localparam int unsigned DataWidth             = 32;
    localparam int unsigned DefaultExtIdWidth     =
        DefaultInIdWidth + cf_math_pkg::idx_width(DefaultNumReq);

    typedef struct packed {
        logic [DefaultInIdWidth-1:0] id;
        logic [DataWidth-1:0]        data;
    } acc_mst_req_t;

    typedef struct packed {
        logic [DefaultExtIdWidth-1:0] id;
        logic [DataWidth-1:0]         data;
    } acc_slv_req_t;

    typedef struct packed {
        logic [DefaultInIdWidth-1:0] id;
        logic [DataWidth-1:0]        data;
    } acc_mst_rsp_t;

    typedef struct packed {
        logic [DefaultExtIdWidth-1:0] id;
        logic [DataWidth-1:0]         data;
    } acc_slv_rsp_t;

endpackage

// File: rtl/cf_math_pkg.sv
// Shared math helpers for index and counter sizing.
package cf_math_pkg;

    // Width of an index able to address num_idx items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/acc_rr_sel.sv
// Round-robin selector with a grant lock held while the downstream port stalls.
module acc_rr_sel #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   eligible,
    input  logic                ready,
    output logic                valid,
    output logic [IdxWidth-1:0] grant
);

    logic [IdxWidth-1:0] ptr;
    logic [IdxWidth-1:0] lock_idx;
    logic [IdxWidth-1:0] search_idx;
    logic                locked;
    logic                found;
    int unsigned         idx;

    always_comb begin
        search_idx = ptr;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = (32'(ptr) + k) % NumReq;
            if (!found && eligible[idx[IdxWidth-1:0]]) begin
                found      = 1'b1;
                search_idx = idx[IdxWidth-1:0];
            end
        end
    end

    assign grant = locked ? lock_idx : search_idx;
    assign valid = locked | found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr      <= '0;
            lock_idx <= '0;
            locked   <= 1'b0;
        end else if (valid && ready) begin
            locked <= 1'b0;
            ptr    <= (grant == IdxWidth'(NumReq - 1)) ? '0 : grant + 1'b1;
        end else if (valid) begin
            // Offer stalled: freeze the grant so payload and valid stay stable.
            locked   <= 1'b1;
            lock_idx <= grant;
        end
    end

endmodule

// File: rtl/acc_req_scheduler.sv
// Shares one accelerator port among NumReq requesters; extends IDs with the requester index.
module acc_req_scheduler import acc_pkg::*; #(
    parameter int unsigned NumReq         = DefaultNumReq,
    parameter int unsigned InIdWidth      = DefaultInIdWidth,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
    parameter type mst_req_chan_t = acc_mst_req_t,
    parameter type slv_req_chan_t = acc_slv_req_t,
    parameter type mst_rsp_chan_t = acc_mst_rsp_t,
    parameter type slv_rsp_chan_t = acc_slv_rsp_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  mst_req_chan_t [NumReq-1:0] mst_q_i,
    input  logic [NumReq-1:0]          mst_q_valid_i,
    output logic [NumReq-1:0]          mst_q_ready_o,
    output mst_rsp_chan_t [NumReq-1:0] mst_p_o,
    output logic [NumReq-1:0]          mst_p_valid_o,
    input  logic [NumReq-1:0]          mst_p_ready_i,
    output slv_req_chan_t              slv_q_o,
    output logic                       slv_q_valid_o,
    input  logic                       slv_q_ready_i,
    input  slv_rsp_chan_t              slv_p_i,
    input  logic                       slv_p_valid_i,
    output logic                       slv_p_ready_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned IdxWidth   = cf_math_pkg::idx_width(NumReq);
    localparam int unsigned ExtIdWidth = InIdWidth + IdxWidth;
    localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);

    logic [NumReq-1:0][CntWidth-1:0] cnt;
    logic [NumReq-1:0]               eligible;
    logic [NumReq-1:0]               p_hs;
    logic [IdxWidth-1:0]             grant;
    logic [IdxWidth-1:0]             tgt;
    logic                            tgt_ok;
    logic                            tgt_empty;

    acc_rr_sel #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) i_rr_sel (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .eligible (eligible),
        .ready    (slv_q_ready_i),
        .valid    (slv_q_valid_o),
        .grant    (grant)
    );

    always_comb begin
        slv_q_o      = '0;
        slv_q_o.id   = {grant, mst_q_i[grant].id};
        slv_q_o.data = mst_q_i[grant].data;
    end

    assign tgt       = slv_p_i.id[ExtIdWidth-1:InIdWidth];
    assign tgt_ok    = {1'b0, tgt} < (IdxWidth + 1)'(NumReq);
    assign tgt_empty = tgt_ok ? (cnt[tgt] == '0) : 1'b1;
    // Unroutable responses are swallowed so the accelerator never deadlocks.
    assign slv_p_ready_o = tgt_ok ? mst_p_ready_i[tgt] : 1'b1;

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i]      = mst_q_valid_i[i] & (cnt[i] < CntWidth'(MaxOutstanding));
            mst_q_ready_o[i] = (grant == IdxWidth'(i)) & slv_q_valid_o & slv_q_ready_i;
            mst_p_valid_o[i] = slv_p_valid_i & tgt_ok & (tgt == IdxWidth'(i));
            p_hs[i]          = mst_p_valid_o[i] & mst_p_ready_i[i];
            mst_p_o[i]       = '0;
            mst_p_o[i].id    = slv_p_i.id[InIdWidth-1:0];
            mst_p_o[i].data  = slv_p_i.data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            err_o <= slv_p_valid_i & slv_p_ready_o & tgt_empty;
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (mst_q_ready_o[i] && !p_hs[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (p_hs[i] && !mst_q_ready_o[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            busy_o = busy_o | (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_acc_req_scheduler.sv
// Bench for acc_req_scheduler: fixed vector table, corner sequences, randomized model check.
module tb_acc_req_scheduler;
    import acc_pkg::*;

    localparam int MO = 4;

    logic               clk = 1'b0;
    logic               rst_ni;
    acc_mst_req_t [1:0] mst_q;
    logic [1:0]         mst_q_valid, mst_q_ready;
    acc_mst_rsp_t [1:0] mst_p;
    logic [1:0]         mst_p_valid, mst_p_ready;
    acc_slv_req_t       slv_q;
    logic               slv_q_valid, slv_q_ready;
    acc_slv_rsp_t       slv_p;
    logic               slv_p_valid, slv_p_ready;
    logic               busy, err;

    int vecs = 0;
    int errs = 0;

    acc_req_scheduler dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .mst_q_i       (mst_q),
        .mst_q_valid_i (mst_q_valid),
        .mst_q_ready_o (mst_q_ready),
        .mst_p_o       (mst_p),
        .mst_p_valid_o (mst_p_valid),
        .mst_p_ready_i (mst_p_ready),
        .slv_q_o       (slv_q),
        .slv_q_valid_o (slv_q_valid),
        .slv_q_ready_i (slv_q_ready),
        .slv_p_i       (slv_p),
        .slv_p_valid_i (slv_p_valid),
        .slv_p_ready_o (slv_p_ready),
        .busy_o        (busy),
        .err_o         (err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [1:0] qv; logic qr; logic pv; logic [5:0] pid; logic [1:0] pr;
        logic sqv; logic [5:0] sid; logic [1:0] mqr; logic spr; logic [1:0] mpv; logic bsy;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] qv, input logic qr, input logic pv,
                         input logic [5:0] pid, input logic [1:0] pr);
        mst_q_valid = qv; slv_q_ready = qr; slv_p_valid = pv;
        slv_p.id = pid; mst_p_ready = pr;
        #2;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        drive(2'b00, 1'b0, 1'b0, 6'h00, 2'b00);
        rst_ni = 1'b0;
        #1;
        chk("rst_sqv",  64'(slv_q_valid), 64'(0));
        chk("rst_mpv",  64'(mst_p_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err",  64'(err), 64'(0));
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic set_ids();
        mst_q[0].id = 5'd3; mst_q[0].data = 32'hA0A0_0000;
        mst_q[1].id = 5'd9; mst_q[1].data = 32'hB1B1_1111;
    endtask

    initial begin
        int mcnt [2];
        int mptr, mhold, g, tgt;
        logic merr, qh, ph, dq, dp;
        logic [1:0] qv, pr;
        logic qr, pv;
        logic [5:0] pid;

        rst_ni = 1'b0;
        slv_p.data = 32'h5555_AAAA;
        set_ids();
        //       qv     qr    pv    pid    pr     sqv   sid    mqr    spr   mpv    busy
        tbl[0] = '{2'b11, 1'b1, 1'b0, 6'h00, 2'b11, 1'b1, 6'h03, 2'b01, 1'b1, 2'b00, 1'b0};
        tbl[1] = '{2'b11, 1'b1, 1'b0, 6'h00, 2'b11, 1'b1, 6'h29, 2'b10, 1'b1, 2'b00, 1'b1};
        tbl[2] = '{2'b11, 1'b1, 1'b0, 6'h00, 2'b11, 1'b1, 6'h03, 2'b01, 1'b1, 2'b00, 1'b1};
        tbl[3] = '{2'b11, 1'b1, 1'b0, 6'h00, 2'b11, 1'b1, 6'h29, 2'b10, 1'b1, 2'b00, 1'b1};
        tbl[4] = '{2'b00, 1'b0, 1'b1, 6'h27, 2'b01, 1'b0, 6'h00, 2'b00, 1'b0, 2'b10, 1'b1};
        tbl[5] = '{2'b00, 1'b0, 1'b1, 6'h27, 2'b01, 1'b0, 6'h00, 2'b00, 1'b0, 2'b10, 1'b1};
        tbl[6] = '{2'b00, 1'b0, 1'b1, 6'h27, 2'b11, 1'b0, 6'h00, 2'b00, 1'b1, 2'b10, 1'b1};
        tbl[7] = '{2'b01, 1'b1, 1'b1, 6'h02, 2'b11, 1'b1, 6'h03, 2'b01, 1'b1, 2'b01, 1'b1};
        tbl[8] = '{2'b00, 1'b0, 1'b0, 6'h02, 2'b11, 1'b0, 6'h00, 2'b00, 1'b1, 2'b00, 1'b1};

        apply_reset();
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].qv, tbl[k].qr, tbl[k].pv, tbl[k].pid, tbl[k].pr);
            chk("tbl_sqv", 64'(slv_q_valid), 64'(tbl[k].sqv));
            if (tbl[k].sqv) chk("tbl_sid", 64'(slv_q.id), 64'(tbl[k].sid));
            chk("tbl_mqr",  64'(mst_q_ready), 64'(tbl[k].mqr));
            chk("tbl_spr",  64'(slv_p_ready), 64'(tbl[k].spr));
            chk("tbl_mpv",  64'(mst_p_valid), 64'(tbl[k].mpv));
            chk("tbl_busy", 64'(busy), 64'(tbl[k].bsy));
            chk("tbl_err",  64'(err), 64'(0));
            if (tbl[k].pv) chk("tbl_pid", 64'(mst_p[tbl[k].pid[5]].id), 64'(tbl[k].pid[4:0]));
            tick();
        end
        // cnt0 must still be 2: exactly two more offloads fit before the limit.
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 1'b1, 1'b0, 6'h00, 2'b11);
            chk("lim_sqv", 64'(slv_q_valid), 64'(k < 2));
            tick();
        end

        // Grant lock across a three-cycle stall with req1 arriving meanwhile.
        apply_reset();
        drive(2'b01, 1'b1, 1'b0, 6'h00, 2'b11);
        chk("lk_pre", 64'(mst_q_ready), 64'(2'b01));
        tick();
        for (int k = 0; k < 3; k++) begin
            drive((k == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0, 6'h00, 2'b11);
            chk("lk_sid",  64'(slv_q.id), 64'(6'h03));
            chk("lk_data", 64'(slv_q.data), 64'(32'hA0A0_0000));
            chk("lk_mqr",  64'(mst_q_ready), 64'(0));
            tick();
        end
        drive(2'b11, 1'b1, 1'b0, 6'h00, 2'b11);
        chk("lk_xfer", 64'(mst_q_ready), 64'(2'b01));
        tick();
        drive(2'b11, 1'b1, 1'b0, 6'h00, 2'b11);
        chk("lk_next_sid", 64'(slv_q.id), 64'(6'h29));
        chk("lk_next_mqr", 64'(mst_q_ready), 64'(2'b10));
        tick();

        // Outstanding limit for req0 while req1 keeps being served.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 1'b1, 1'b0, 6'h00, 2'b11);
            chk("mo_fill", 64'(mst_q_ready), 64'(2'b01));
            tick();
        end
        drive(2'b11, 1'b1, 1'b0, 6'h00, 2'b11);
        chk("mo_req1", 64'(mst_q_ready), 64'(2'b10));
        tick();
        drive(2'b01, 1'b1, 1'b1, 6'h00, 2'b11);
        chk("mo_block", 64'(slv_q_valid), 64'(0));
        chk("mo_mpv",   64'(mst_p_valid), 64'(2'b01));
        tick();
        drive(2'b01, 1'b1, 1'b0, 6'h00, 2'b11);
        chk("mo_again", 64'(mst_q_ready), 64'(2'b01));
        tick();

        // Response with nothing outstanding, then reset with offloads in flight.
        apply_reset();
        drive(2'b00, 1'b0, 1'b1, 6'h21, 2'b11);
        chk("er_mpv", 64'(mst_p_valid), 64'(2'b10));
        chk("er_pre", 64'(err), 64'(0));
        tick();
        drive(2'b00, 1'b0, 1'b0, 6'h00, 2'b11);
        chk("er_pulse", 64'(err), 64'(1));
        chk("er_busy",  64'(busy), 64'(0));
        tick();
        drive(2'b00, 1'b0, 1'b0, 6'h00, 2'b11);
        chk("er_end", 64'(err), 64'(0));
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 1'b1, 1'b0, 6'h00, 2'b11);
            tick();
        end
        drive(2'b00, 1'b0, 1'b0, 6'h00, 2'b11);
        chk("rs_busy_pre", 64'(busy), 64'(1));
        rst_ni = 1'b0;
        #1;
        chk("rs_busy", 64'(busy), 64'(0));
        tick();
        rst_ni = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 6'h00, 2'b11);
        chk("rs_mpv", 64'(mst_p_valid), 64'(2'b01));
        tick();
        drive(2'b00, 1'b0, 1'b0, 6'h00, 2'b11);
        chk("rs_err", 64'(err), 64'(1));
        tick();

        // Randomized traffic against a transaction-level model.
        apply_reset();
        mcnt[0] = 0; mcnt[1] = 0; mptr = 0; mhold = -1; merr = 1'b0;
        for (int n = 0; n < 600; n++) begin
            qv  = 2'($urandom);
            if (mhold >= 0) qv[mhold] = 1'b1;
            else begin
                mst_q[0].id = 5'($urandom); mst_q[0].data = $urandom;
                mst_q[1].id = 5'($urandom); mst_q[1].data = $urandom;
            end
            qr  = ($urandom_range(0, 3) != 0);
            pv  = ($urandom_range(0, 2) == 0);
            tgt = int'($urandom_range(0, 1));
            pid = {tgt[0], 5'($urandom)};
            pr  = 2'($urandom);
            drive(qv, qr, pv, pid, pr);

            g = mhold;
            if (g < 0)
                for (int k = 0; k < 2; k++)
                    if (g < 0 && qv[(mptr + k) % 2] && mcnt[(mptr + k) % 2] < MO) g = (mptr + k) % 2;
            chk("rnd_sqv", 64'(slv_q_valid), 64'(g >= 0));
            if (g >= 0) begin
                chk("rnd_sid",  64'(slv_q.id), 64'({g[0], mst_q[g].id}));
                chk("rnd_data", 64'(slv_q.data), 64'(mst_q[g].data));
            end
            chk("rnd_mqr",  64'(mst_q_ready), 64'((g >= 0 && qr) ? (1 << g) : 0));
            chk("rnd_spr",  64'(slv_p_ready), 64'(pr[tgt]));
            chk("rnd_mpv",  64'(mst_p_valid), 64'(pv ? (1 << tgt) : 0));
            if (pv) chk("rnd_pid", 64'(mst_p[tgt].id), 64'(pid[4:0]));
            chk("rnd_busy", 64'(busy), 64'(mcnt[0] != 0 || mcnt[1] != 0));
            chk("rnd_err",  64'(err), 64'(merr));

            qh   = (g >= 0) && qr;
            ph   = pv && pr[tgt];
            merr = ph && (mcnt[tgt] == 0);
            for (int i = 0; i < 2; i++) begin
                dq = qh && (g == i);
                dp = ph && (tgt == i);
                if (dq && !dp) mcnt[i]++;
                else if (dp && !dq && mcnt[i] > 0) mcnt[i]--;
            end
            if (qh) begin
                mptr  = (g + 1) % 2;
                mhold = -1;
            end else if (g >= 0) begin
                mhold = g;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
